divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 132 +++++++++++++
 tb/tb_divider.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per clock.
// Result is {remainder, quotient}, held while start_i stays high after completion.
//
// state  | meaning
// FREE   | idle, waiting for start_i without annul_i
// BYZERO | divisor was zero, result 0 is published on the next edge
// ON     | 32 shift-subtract iterations in progress
// END    | result_o valid, held until start_i drops or annul_i
module divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic        sgn_q, s1_q, s2_q;
   logic [31:0] quo_q, rem_q, dsor_q;
   logic [4:0]  cnt_q;

   logic        accept;
   logic [31:0] mag1, mag2;
   logic [32:0] rem_sh, diff;
   logic        ge;
   logic [31:0] quo_nx, rem_nx, quo_fix, rem_fix;
   logic        neg_q, neg_r;
   logic [63:0] result_d;
   logic        ready_d;

   assign accept = (state_q == FREE) && start_i && !annul_i;
   assign mag1   = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign mag2   = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // One restoring step: shift the next dividend bit into the partial remainder.
   assign rem_sh = {rem_q, quo_q[31]};
   assign diff   = rem_sh - {1'b0, dsor_q};
   assign ge     = (rem_sh >= {1'b0, dsor_q});
   assign quo_nx = {quo_q[30:0], ge};
   assign rem_nx = ge ? diff[31:0] : rem_sh[31:0];

   assign neg_q   = sgn_q && (s1_q ^ s2_q);
   assign neg_r   = sgn_q && s1_q;
   assign quo_fix = neg_q ? (~quo_nx + 32'd1) : quo_nx;
   assign rem_fix = neg_r ? (~rem_nx + 32'd1) : rem_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FREE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      result_d = 64'd0;
      ready_d  = 1'b0;
      case (state_q)
         FREE: begin
            if (start_i && !annul_i)
               state_d = (opdata2_i == 32'd0) ? BYZERO : ON;
         end
         BYZERO: begin
            if (annul_i) begin
               state_d = FREE;
            end else begin
               state_d = END;
               ready_d = 1'b1;
            end
         end
         ON: begin
            if (annul_i) begin
               state_d = FREE;
            end else if (cnt_q == 5'd31) begin
               state_d  = END;
               ready_d  = 1'b1;
               result_d = {rem_fix, quo_fix};
            end
         end
         END: begin
            if (start_i && !annul_i) begin
               ready_d  = 1'b1;
               result_d = result_o;
            end else begin
               state_d = FREE;
            end
         end
         default: state_d = FREE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sgn_q    <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         quo_q    <= 32'd0;
         rem_q    <= 32'd0;
         dsor_q   <= 32'd0;
         cnt_q    <= 5'd0;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         result_o <= result_d;
         ready_o  <= ready_d;
         if (accept) begin
            sgn_q  <= signed_div_i;
            s1_q   <= opdata1_i[31];
            s2_q   <= opdata2_i[31];
            quo_q  <= mag1;
            rem_q  <= 32'd0;
            dsor_q <= mag2;
            cnt_q  <= 5'd0;
         end else if (state_q == ON && !annul_i) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: arithmetic reference model plus directed vectors
// covering latency, sign handling, divide-by-zero, annul, handshake and reset.
module tb_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = 32'd0;
   logic [31:0] opdata2_i = 32'd0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [63:0] exp_result = 64'd0;
   bit          forbid_ready = 1'b0;

   divider dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   // Reference: plain integer division; 64-bit arithmetic lets the
   // most-negative / -1 case wrap naturally when truncated to 32 bits.
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Every cycle: a valid result must match the model, an idle result must be 0.
   always @(negedge clk) begin
      if (ready_o) chk("cmp_result", result_o, exp_result);
      else         chk("cmp_idle_zero", result_o, 64'd0);
      if (forbid_ready) chk("cmp_no_ready", {63'd0, ready_o}, 64'd0);
   end

   task automatic do_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] lit, input int exp_lat, input bit scramble);
      int n;
      chk({name, "_model_pin"}, model(s, a, b), lit);
      exp_result = model(s, a, b);
      @(negedge clk);
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
         if (scramble && n == 5) begin
            signed_div_i = ~s;
            opdata1_i    = 32'h5A5A_A5A5;
            opdata2_i    = 32'h0000_0003;
         end
      end while (!ready_o && n < 40);
      chk({name, "_latency"}, 64'(n), 64'(exp_lat));
      chk({name, "_result"}, result_o, exp_result);
   endtask

   task automatic drop_start(input string name);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({name, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
      chk({name, "_drop_result"}, result_o, 64'd0);
   endtask

   task automatic quiet(input int cycles);
      forbid_ready = 1'b1;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      forbid_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", {63'd0, ready_o}, 64'd0);
      chk("reset_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("end_hold_ready", {63'd0, ready_o}, 64'd1);
         chk("end_hold_result", result_o, {32'h2, 32'hE});
      end
      drop_start("u100_7");

      do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
      drop_start("s_m7_2");
      do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 1'b0);
      drop_start("s_7_m2");
      do_div("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE}, 33, 1'b0);
      drop_start("s_m100_m7");
      do_div("u_big_16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 1'b0);
      drop_start("u_big_16");
      do_div("byzero", 1'b0, 32'h1234_5678, 32'd0, 64'd0, 2, 1'b0);
      drop_start("byzero");
      do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1'b0);
      drop_start("s_min_m1");
      do_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33, 1'b0);
      drop_start("u_max_1");
      do_div("scramble", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, 1'b1);
      drop_start("scramble");

      // Annul on edge 10 of 100/7, then 9/3 must run normally from FREE.
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      forbid_ready = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      quiet(40);
      do_div("after_annul", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33, 1'b0);
      drop_start("after_annul");

      // Annul while in BYZERO.
      @(negedge clk);
      opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
      forbid_ready = 1'b1;
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      quiet(5);

      // Reset in END clears outputs asynchronously.
      do_div("pre_rst", 1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 33, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_async_result", result_o, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst = 1'b0;

      // Reset mid-ON: no ready pulse, next start accepted right away.
      @(negedge clk);
      opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      forbid_ready = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      quiet(40);
      do_div("after_rst", 1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, 33, 1'b0);
      drop_start("after_rst");

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
